// File: rtl/wb_write_arbiter.sv
// Register-file write-back arbiter: merges the ALU pipe and a long-latency unit
// onto one registered write port, buffering long-latency losers in a small FIFO.
module wb_write_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 6,
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          alu_valid,
   input  logic [ADDR_WIDTH-1:0]         alu_addr,
   input  logic [DATA_WIDTH-1:0]         alu_data,
   input  logic                          ll_valid,
   output logic                          ll_ready,
   input  logic [ADDR_WIDTH-1:0]         ll_addr,
   input  logic [DATA_WIDTH-1:0]         ll_data,
   output logic                          stall_alu,
   output logic                          alu_drop_err,
   input  logic [ADDR_WIDTH-1:0]         pend_query_addr,
   output logic                          pend_hit,
   output logic                          wb_uses_rw,
   output logic [ADDR_WIDTH-1:0]         wb_rw_addr,
   output logic [DATA_WIDTH-1:0]         wb_rw_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [AGE_W-1:0] LIMIT_C = AGE_W'(STARVE_LIMIT);

   logic [ADDR_WIDTH-1:0] mem_addr_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      rd_q, wr_q;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [AGE_W-1:0]      age_q;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  drop_q, drop_d;

   logic                  alu_qual, ll_keep, fifo_empty, push, pop;
   logic [PTR_W-1:0]      off_w [FIFO_DEPTH];

   // ll_ready looks only at the current occupancy; a same-cycle pop does not free a slot.
   assign ll_ready   = !rst && (count_q < DEPTH_C);
   assign alu_qual   = alu_valid && (alu_addr != '0);
   assign ll_keep    = ll_valid && ll_ready && (ll_addr != '0);
   assign fifo_empty = (count_q == '0);
   assign stall_alu  = (age_q == LIMIT_C);

   assign wb_uses_rw   = we_q;
   assign wb_rw_addr   = waddr_q;
   assign wb_rw_data   = wdata_q;
   assign alu_drop_err = drop_q;
   assign fifo_count   = count_q;

   always_comb begin
      pop     = 1'b0;
      push    = 1'b0;
      we_d    = 1'b0;
      waddr_d = '0;
      wdata_d = '0;
      drop_d  = 1'b0;
      if (stall_alu) begin
         pop     = 1'b1;
         push    = ll_keep;
         we_d    = 1'b1;
         waddr_d = mem_addr_q[rd_q];
         wdata_d = mem_data_q[rd_q];
         drop_d  = alu_qual;
      end else if (alu_qual) begin
         push    = ll_keep;
         we_d    = 1'b1;
         waddr_d = alu_addr;
         wdata_d = alu_data;
      end else if (!fifo_empty) begin
         pop     = 1'b1;
         push    = ll_keep;
         we_d    = 1'b1;
         waddr_d = mem_addr_q[rd_q];
         wdata_d = mem_data_q[rd_q];
      end else if (ll_keep) begin
         we_d    = 1'b1;
         waddr_d = ll_addr;
         wdata_d = ll_data;
      end
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   // An entry is live when its distance from the read pointer is below the occupancy.
   always_comb begin
      pend_hit = 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         off_w[i] = PTR_W'(i) - rd_q;
         if (({1'b0, off_w[i]} < count_q) && (mem_addr_q[i] == pend_query_addr) &&
             (pend_query_addr != '0)) begin
            pend_hit = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
         age_q   <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         drop_q  <= 1'b0;
      end else begin
         if (pop) begin
            rd_q <= rd_q + 1'b1;
         end
         if (push) begin
            wr_q <= wr_q + 1'b1;
         end
         count_q <= count_d;
         if (pop || fifo_empty) begin
            age_q <= '0;
         end else if (age_q != LIMIT_C) begin
            age_q <= age_q + 1'b1;
         end
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         drop_q  <= drop_d;
      end
   end

   // Storage carries no reset; liveness is defined by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_addr_q[wr_q] <= ll_addr;
         mem_data_q[wr_q] <= ll_data;
      end
   end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_wb_write_arbiter;

   localparam int DW    = 32;
   localparam int AW    = 6;
   localparam int DEPTH = 4;
   localparam int LIMIT = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          alu_valid = 1'b0;
   logic [AW-1:0] alu_addr = '0;
   logic [DW-1:0] alu_data = '0;
   logic          ll_valid = 1'b0;
   logic          ll_ready;
   logic [AW-1:0] ll_addr = '0;
   logic [DW-1:0] ll_data = '0;
   logic          stall_alu;
   logic          alu_drop_err;
   logic [AW-1:0] pend_query_addr = '0;
   logic          pend_hit;
   logic          wb_uses_rw;
   logic [AW-1:0] wb_rw_addr;
   logic [DW-1:0] wb_rw_data;
   logic [2:0]    fifo_count;

   int total = 0;
   int bad   = 0;

   wb_write_arbiter #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
      .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_addr(ll_addr), .ll_data(ll_data),
      .stall_alu(stall_alu), .alu_drop_err(alu_drop_err),
      .pend_query_addr(pend_query_addr), .pend_hit(pend_hit),
      .wb_uses_rw(wb_uses_rw), .wb_rw_addr(wb_rw_addr), .wb_rw_data(wb_rw_data),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   // Reference model: pending long-latency writes as a plain queue plus a wait counter.
   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   ent_t          mq[$];
   int            m_age  = 0;
   logic          m_we   = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_data = '0;
   logic          m_drop = 1'b0;

   function automatic bit model_hit(input logic [AW-1:0] q);
      foreach (mq[i]) if (q != 0 && mq[i].a == q) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_step();
      ent_t e;
      bit   aluq, keep, starve, popped;
      int   sz0;
      if (rst) begin
         mq.delete();
         m_age = 0; m_we = 1'b0; m_addr = '0; m_data = '0; m_drop = 1'b0;
         return;
      end
      sz0    = mq.size();
      keep   = ll_valid && (sz0 < DEPTH) && (ll_addr != 0);
      aluq   = alu_valid && (alu_addr != 0);
      starve = (m_age == LIMIT);
      popped = 1'b0;
      m_we = 1'b0; m_addr = '0; m_data = '0; m_drop = 1'b0;
      if (starve || (!aluq && sz0 > 0)) begin
         e = mq.pop_front();
         m_we = 1'b1; m_addr = e.a; m_data = e.d;
         popped = 1'b1;
         m_drop = starve && aluq;
      end else if (aluq) begin
         m_we = 1'b1; m_addr = alu_addr; m_data = alu_data;
      end else if (keep) begin
         m_we = 1'b1; m_addr = ll_addr; m_data = ll_data;
         keep = 1'b0;
      end
      if (keep) begin
         e.a = ll_addr; e.d = ll_data;
         mq.push_back(e);
      end
      if (popped || sz0 == 0) m_age = 0;
      else if (m_age < LIMIT) m_age++;
   endtask

   task automatic clk_cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      rst = 1'b0; alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
      ll_valid = 1'b0; ll_addr = '0; ll_data = '0; pend_query_addr = '0;
   endtask

   task automatic do_reset();
      set_idle();
      rst = 1'b1;
      clk_cycle();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; alu_valid = 1'b1; alu_addr = 6'd5; alu_data = 32'h1;
      ll_valid = 1'b1; ll_addr = 6'd3; ll_data = 32'h2;
      #1;
      total++; if (ll_ready !== 1'b0) begin bad++; $display("FAIL rst_ll_ready got=%0b exp=0", ll_ready); end
      clk_cycle();
      clk_cycle();
      total++; if (wb_uses_rw !== 1'b0) begin bad++; $display("FAIL rst_we got=%0b exp=0", wb_uses_rw); end
      total++; if (wb_rw_addr !== '0) begin bad++; $display("FAIL rst_addr got=%0h exp=0", wb_rw_addr); end
      total++; if (wb_rw_data !== '0) begin bad++; $display("FAIL rst_data got=%0h exp=0", wb_rw_data); end
      total++; if (stall_alu !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0b exp=0", stall_alu); end
      total++; if (alu_drop_err !== 1'b0) begin bad++; $display("FAIL rst_drop got=%0b exp=0", alu_drop_err); end
      total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", fifo_count); end
      set_idle();
   endtask

   task automatic test_alu_only();
      do_reset();
      alu_valid = 1'b1; alu_addr = 6'd5; alu_data = 32'hDEADBEEF;
      clk_cycle();
      total++; if (wb_uses_rw !== 1'b1) begin bad++; $display("FAIL alu_we got=%0b exp=1", wb_uses_rw); end
      total++; if (wb_rw_addr !== 6'd5) begin bad++; $display("FAIL alu_addr got=%0d exp=5", wb_rw_addr); end
      total++; if (wb_rw_data !== 32'hDEADBEEF) begin bad++; $display("FAIL alu_data got=%0h exp=deadbeef", wb_rw_data); end
      alu_addr = 6'd0; alu_data = 32'h55;
      clk_cycle();
      total++; if (wb_uses_rw !== 1'b0) begin bad++; $display("FAIL alu_addr0_we got=%0b exp=0", wb_uses_rw); end
      set_idle();
   endtask

   task automatic test_bypass();
      do_reset();
      ll_valid = 1'b1; ll_addr = 6'd9; ll_data = 32'h1234;
      #1;
      total++; if (ll_ready !== 1'b1) begin bad++; $display("FAIL byp_ready got=%0b exp=1", ll_ready); end
      clk_cycle();
      set_idle();
      total++; if (wb_uses_rw !== 1'b1 || wb_rw_addr !== 6'd9 || wb_rw_data !== 32'h1234) begin
         bad++; $display("FAIL byp_write got=%0b/%0d/%0h exp=1/9/1234", wb_uses_rw, wb_rw_addr, wb_rw_data);
      end
      total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL byp_count got=%0d exp=0", fifo_count); end
   endtask

   task automatic test_collision();
      do_reset();
      alu_valid = 1'b1; alu_addr = 6'd3; alu_data = 32'hA0A0;
      ll_valid  = 1'b1; ll_addr  = 6'd4; ll_data  = 32'hB0B0;
      clk_cycle();
      set_idle();
      pend_query_addr = 6'd4;
      #1;
      total++; if (wb_uses_rw !== 1'b1 || wb_rw_addr !== 6'd3 || wb_rw_data !== 32'hA0A0) begin
         bad++; $display("FAIL col_alu got=%0b/%0d/%0h exp=1/3/a0a0", wb_uses_rw, wb_rw_addr, wb_rw_data);
      end
      total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL col_count got=%0d exp=1", fifo_count); end
      total++; if (pend_hit !== 1'b1) begin bad++; $display("FAIL col_hit got=%0b exp=1", pend_hit); end
      clk_cycle();
      total++; if (wb_uses_rw !== 1'b1 || wb_rw_addr !== 6'd4 || wb_rw_data !== 32'hB0B0) begin
         bad++; $display("FAIL col_ll got=%0b/%0d/%0h exp=1/4/b0b0", wb_uses_rw, wb_rw_addr, wb_rw_data);
      end
      total++; if (pend_hit !== 1'b0) begin bad++; $display("FAIL col_hit_after got=%0b exp=0", pend_hit); end
      set_idle();
   endtask

   task automatic test_full();
      do_reset();
      for (int k = 0; k < 5; k++) begin
         alu_valid = 1'b1; alu_addr = AW'(10 + k); alu_data = 32'(k);
         ll_valid  = 1'b1; ll_addr  = AW'(20 + k); ll_data  = 32'(32'hC00 + k);
         #1;
         total++; if (ll_ready !== (k < 4)) begin bad++; $display("FAIL full_ready%0d got=%0b exp=%0b", k, ll_ready, k < 4); end
         clk_cycle();
      end
      set_idle();
      #1;
      total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", fifo_count); end
      for (int k = 0; k < 4; k++) begin
         clk_cycle();
         total++; if (wb_uses_rw !== 1'b1 || wb_rw_addr !== AW'(20 + k) || wb_rw_data !== 32'(32'hC00 + k)) begin
            bad++; $display("FAIL full_drain%0d got=%0b/%0d/%0h exp=1/%0d/%0h", k, wb_uses_rw, wb_rw_addr, wb_rw_data, 20 + k, 32'hC00 + k);
         end
      end
      total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL full_empty got=%0d exp=0", fifo_count); end
   endtask

   task automatic test_starve(input bit hold_alu);
      do_reset();
      alu_valid = 1'b1; alu_addr = 6'd1; alu_data = 32'h11;
      ll_valid  = 1'b1; ll_addr  = 6'd7; ll_data  = 32'h7777;
      clk_cycle();
      ll_valid = 1'b0;
      for (int j = 0; j < LIMIT; j++) begin
         alu_addr = AW'(30 + j);
         #1;
         total++; if (stall_alu !== 1'b0) begin bad++; $display("FAIL starve_early%0d got=%0b exp=0", j, stall_alu); end
         clk_cycle();
      end
      alu_valid = hold_alu; alu_addr = 6'd12; alu_data = 32'hBAD;
      #1;
      total++; if (stall_alu !== 1'b1) begin bad++; $display("FAIL starve_stall got=%0b exp=1", stall_alu); end
      clk_cycle();
      set_idle();
      #1;
      total++; if (wb_uses_rw !== 1'b1 || wb_rw_addr !== 6'd7 || wb_rw_data !== 32'h7777) begin
         bad++; $display("FAIL starve_pop got=%0b/%0d/%0h exp=1/7/7777", wb_uses_rw, wb_rw_addr, wb_rw_data);
      end
      total++; if (stall_alu !== 1'b0) begin bad++; $display("FAIL starve_clear got=%0b exp=0", stall_alu); end
      total++; if (alu_drop_err !== hold_alu) begin bad++; $display("FAIL starve_drop got=%0b exp=%0b", alu_drop_err, hold_alu); end
      clk_cycle();
      total++; if (alu_drop_err !== 1'b0) begin bad++; $display("FAIL starve_drop_pulse got=%0b exp=0", alu_drop_err); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         alu_valid = 1'b1; alu_addr = AW'(40 + k); alu_data = 32'(k);
         ll_valid  = 1'b1; ll_addr  = AW'(50 + k); ll_data  = 32'(32'hE00 + k);
         clk_cycle();
      end
      set_idle();
      #1;
      total++; if (fifo_count !== 3'd3) begin bad++; $display("FAIL mid_count got=%0d exp=3", fifo_count); end
      rst = 1'b1;
      clk_cycle();
      rst = 1'b0;
      pend_query_addr = 6'd50;
      #1;
      total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL mid_flush got=%0d exp=0", fifo_count); end
      total++; if (wb_uses_rw !== 1'b0) begin bad++; $display("FAIL mid_we got=%0b exp=0", wb_uses_rw); end
      total++; if (pend_hit !== 1'b0) begin bad++; $display("FAIL mid_hit got=%0b exp=0", pend_hit); end
      for (int k = 0; k < 6; k++) begin
         clk_cycle();
         total++; if (wb_uses_rw !== 1'b0) begin bad++; $display("FAIL mid_stale%0d got=%0b/%0d exp=0", k, wb_uses_rw, wb_rw_addr); end
      end
   endtask

   task automatic test_random();
      bit exp_hit;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         rst       = ($urandom_range(0, 199) == 0);
         alu_valid = ($urandom_range(0, 99) < 70);
         alu_addr  = AW'($urandom_range(0, 7));
         alu_data  = $urandom;
         ll_valid  = $urandom_range(0, 1) == 1;
         ll_addr   = AW'($urandom_range(0, 7));
         ll_data   = $urandom;
         pend_query_addr = AW'($urandom_range(0, 7));
         if (m_age == LIMIT && $urandom_range(0, 1) == 1) alu_valid = 1'b0;
         #1;
         exp_hit = model_hit(pend_query_addr);
         total++; if (ll_ready !== (!rst && mq.size() < DEPTH)) begin bad++; $display("FAIL rnd_ready@%0d got=%0b exp=%0b", i, ll_ready, !rst && mq.size() < DEPTH); end
         total++; if (stall_alu !== (m_age == LIMIT)) begin bad++; $display("FAIL rnd_stall@%0d got=%0b exp=%0b", i, stall_alu, m_age == LIMIT); end
         total++; if (fifo_count !== 3'(mq.size())) begin bad++; $display("FAIL rnd_count@%0d got=%0d exp=%0d", i, fifo_count, mq.size()); end
         total++; if (pend_hit !== exp_hit) begin bad++; $display("FAIL rnd_hit@%0d got=%0b exp=%0b", i, pend_hit, exp_hit); end
         clk_cycle();
         total++; if (wb_uses_rw !== m_we) begin bad++; $display("FAIL rnd_we@%0d got=%0b exp=%0b", i, wb_uses_rw, m_we); end
         if (m_we) begin
            total++; if (wb_rw_addr !== m_addr || wb_rw_data !== m_data) begin
               bad++; $display("FAIL rnd_wdata@%0d got=%0d/%0h exp=%0d/%0h", i, wb_rw_addr, wb_rw_data, m_addr, m_data);
            end
         end
         total++; if (alu_drop_err !== m_drop) begin bad++; $display("FAIL rnd_drop@%0d got=%0b exp=%0b", i, alu_drop_err, m_drop); end
      end
      set_idle();
   endtask

   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_alu_only();
      test_bypass();
      test_collision();
      test_full();
      test_starve(1'b0);
      test_starve(1'b1);
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Write-back arbiter that drives the register file's single synchronous write port. It merges two write sources into at most one write per cycle:
- the in-order ALU pipe, which cannot be back-pressured;
- a variable-latency long-latency unit (loads, multiply/divide) using a valid/ready handshake.

Long-latency results that lose arbitration wait in a small FIFO. An anti-starvation counter requests an ALU stall when the FIFO head has waited too long.

## Interface
Parameters:
- DATA_WIDTH, 32, write data width
- ADDR_WIDTH, 6, register address width (64-entry file)
- FIFO_DEPTH, 4, long-latency buffer entries (power of two)
- STARVE_LIMIT, 8, consecutive non-pop cycles with FIFO non-empty before stall request

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous to clk, active-high
- alu_valid  in  1  ALU result present this cycle
- alu_addr  in  ADDR_WIDTH  ALU destination register
- alu_data  in  DATA_WIDTH  ALU result
- ll_valid  in  1  long-latency result offered
- ll_ready  out  1  arbiter accepts long-latency result this cycle
- ll_addr  in  ADDR_WIDTH  long-latency destination register
- ll_data  in  DATA_WIDTH  long-latency result
- stall_alu  out  1  request to upstream: hold alu_valid low
- alu_drop_err  out  1  one-cycle pulse: an ALU write was discarded
- pend_query_addr  in  ADDR_WIDTH  hazard lookup address
- pend_hit  out  1  some FIFO entry targets pend_query_addr (combinational)
- wb_uses_rw  out  1  register file write enable (registered)
- wb_rw_addr  out  ADDR_WIDTH  write address (registered)
- wb_rw_data  out  DATA_WIDTH  write data (registered)
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
Input qualification:
- An ALU write with alu_addr == 0 is ignored.
- A long-latency transfer is a handshake: ll_valid && ll_ready.
- A long-latency transfer with ll_addr == 0 is accepted and dropped; it is neither enqueued nor written.

ll_ready = !rst && (fifo_count < FIFO_DEPTH). It is computed from the current count only, so a pop in the same cycle does not free space.

Per-cycle winner, in priority order:
1. stall_alu == 1 (FIFO is then non-empty): pop the FIFO head and write it. If an ALU write is also qualified, that ALU write is lost and alu_drop_err pulses next cycle.
2. Qualified ALU write: write the ALU result. Any accepted long-latency transfer is enqueued.
3. FIFO non-empty: pop the head and write it. Any accepted long-latency transfer is enqueued behind it.
4. FIFO empty and a long-latency transfer is accepted: bypass it straight to the write port, with no enqueue.
5. Otherwise: wb_uses_rw = 0 next cycle.

Other rules:
- Push and pop in the same cycle are legal; occupancy is unchanged.
- The FIFO is strictly in-order, with wrap-around pointers of $clog2(FIFO_DEPTH) bits.

Age counter (saturating at STARVE_LIMIT):
- Clears to 0 on any pop, or when the FIFO is empty.
- Increments on each cycle the FIFO is non-empty and no pop occurs.
- stall_alu = (age == STARVE_LIMIT). It is registered state, not a function of the current inputs.

pend_hit compares pend_query_addr against all valid FIFO entries. Address 0 never hits.

Ordering between sources is not checked here. Two writes to the same register from different sources are written in arbitration order. The upstream scoreboard must use pend_hit and its own tracking to prevent WAW reordering.

## Timing
- Reset state: wb_uses_rw, wb_rw_addr, wb_rw_data, stall_alu, alu_drop_err = 0; FIFO empty; fifo_count = 0; age = 0; ll_ready = 0 while rst is high.
- rst asserted mid-operation flushes all queued entries. No write is issued in the cycle after reset.
- Write latency is exactly 1 cycle: a winner chosen in cycle N appears on the wb_* outputs in cycle N+1, and the register file commits it at the end of cycle N+1.
- A queued entry pops no earlier than the cycle after its enqueue.
- A full FIFO under continuous ALU writes asserts stall_alu STARVE_LIMIT cycles after the FIFO became non-empty. The stall lasts one cycle per forced pop.
- alu_drop_err is a single-cycle pulse in the same cycle as the corresponding (missing) write slot.

## Test plan
- ALU only: alu_valid=1, addr=5, data=0xDEADBEEF in cycle 1 -> wb_uses_rw=1, addr 5, data 0xDEADBEEF in cycle 2; addr 0 gives no write.
- LL bypass: FIFO empty, ALU idle, ll_valid addr=9 data=0x1234 -> ll_ready=1, write addr 9 next cycle, fifo_count stays 0.
- Collision: ALU addr 3 and LL addr 4 in the same cycle -> addr 3 written in cycle N+1, fifo_count=1, addr 4 written in cycle N+2 with ALU idle; pend_hit=1 for query 4 during cycle N+1 only.
- Full/back-pressure: ALU busy every cycle, 5 LL offers -> ll_ready drops after 4 accepted, fifo_count=4.
- Starvation: continuous ALU writes, 1 queued entry -> stall_alu=1 after 8 cycles; upstream holds alu_valid=0 -> head written, stall_alu clears next cycle. Repeat with alu_valid held high -> alu_drop_err pulses once.
- Reset mid-run: FIFO holding 3 entries, assert rst for 1 cycle -> fifo_count=0, wb_uses_rw=0, no stale entry ever written.
